// File: rtl/intersection_scheduler.sv
// Phase scheduler for a main road, a side road and a pedestrian crossing.
// Main road rests on green. Side-road and walk phases run only on request, with all-red clearance between them.
module intersection_scheduler #(
  parameter int unsigned T_ALL_RED   = 1,
  parameter int unsigned T_MIN_GREEN = 8,
  parameter int unsigned T_YELLOW    = 3,
  parameter int unsigned T_SIDE_MAX  = 6,
  parameter int unsigned T_WALK      = 5,
  parameter int unsigned CW          = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       side_req,
  input  logic       ped_req,
  output logic [1:0] main_light,
  output logic [1:0] side_light,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    ST_RED_M  = 3'd0,
    ST_MAIN_G = 3'd1,
    ST_MAIN_Y = 3'd2,
    ST_RED_S  = 3'd3,
    ST_SIDE_G = 3'd4,
    ST_SIDE_Y = 3'd5,
    ST_WALK   = 3'd6
  } state_e;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_GREEN  = 2'b01;
  localparam logic [1:0] LIGHT_YELLOW = 2'b10;

  // Each end value is the timer count on whose tick the state is left.
  localparam logic [CW-1:0] ALL_RED_END   = CW'(T_ALL_RED - 1);
  localparam logic [CW-1:0] MIN_GREEN_END = CW'(T_MIN_GREEN - 1);
  localparam logic [CW-1:0] YELLOW_END    = CW'(T_YELLOW - 1);
  localparam logic [CW-1:0] SIDE_MAX_END  = CW'(T_SIDE_MAX - 1);
  localparam logic [CW-1:0] WALK_END      = CW'(T_WALK - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   timer_q, timer_d;
  logic            ped_pending_q, ped_pending_d;
  logic            target_q, target_d;
  logic            ped_ack_q, ped_ack_d;
  logic            enter_walk;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_RED_M;
      timer_q       <= '0;
      ped_pending_q <= 1'b0;
      target_q      <= 1'b0;
      ped_ack_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      ped_pending_q <= ped_pending_d;
      target_q      <= target_d;
      ped_ack_q     <= ped_ack_d;
    end
  end

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    case (state_q)
      ST_RED_M:  if (tick && timer_q == ALL_RED_END) state_d = ST_MAIN_G;
      ST_MAIN_G: begin
        if (tick && timer_q == MIN_GREEN_END) begin
          if (ped_pending_q) begin
            state_d  = ST_MAIN_Y;
            target_d = 1'b1;
          end else if (side_req) begin
            state_d  = ST_MAIN_Y;
            target_d = 1'b0;
          end
        end
      end
      ST_MAIN_Y: if (tick && timer_q == YELLOW_END) state_d = ST_RED_S;
      ST_RED_S:  if (tick && timer_q == ALL_RED_END) state_d = target_q ? ST_WALK : ST_SIDE_G;
      ST_SIDE_G: if (tick && (!side_req || timer_q == SIDE_MAX_END)) state_d = ST_SIDE_Y;
      ST_SIDE_Y: if (tick && timer_q == YELLOW_END) state_d = ST_RED_M;
      ST_WALK:   if (tick && timer_q == WALK_END) state_d = ST_RED_M;
      default:   state_d = ST_RED_M;
    endcase
  end

  // Main green parks its timer at the minimum so a later request is served on its first tick.
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (tick && !(state_q == ST_MAIN_G && timer_q == MIN_GREEN_END)) begin
      timer_d = timer_q + CW'(1);
    end
  end

  // A press on the walk-entry cycle survives the clear and is served next round.
  assign enter_walk    = (state_d == ST_WALK) && (state_q != ST_WALK);
  assign ped_pending_d = ped_req | (ped_pending_q & ~enter_walk);
  assign ped_ack_d     = enter_walk;

  always_comb begin
    main_light = LIGHT_RED;
    side_light = LIGHT_RED;
    walk       = 1'b0;
    case (state_q)
      ST_MAIN_G: main_light = LIGHT_GREEN;
      ST_MAIN_Y: main_light = LIGHT_YELLOW;
      ST_SIDE_G: side_light = LIGHT_GREEN;
      ST_SIDE_Y: side_light = LIGHT_YELLOW;
      ST_WALK:   walk       = 1'b1;
      default:   ;
    endcase
  end

  assign ped_ack = ped_ack_q;
  assign phase   = state_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Bench for intersection_scheduler: directed phase tables, a mid-phase reset, and randomized runs
// checked against a tick-counting reference model. A continuous check covers the light invariants.
module tb_intersection_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       side_req = 1'b0;
  logic       ped_req = 1'b0;
  logic [1:0] main_light, side_light;
  logic       walk, ped_ack;
  logic [2:0] phase;

  int n_tests = 0;
  int n_fail  = 0;
  bit inv_on  = 1'b0;

  intersection_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .side_req   (side_req),
    .ped_req    (ped_req),
    .main_light (main_light),
    .side_light (side_light),
    .walk       (walk),
    .ped_ack    (ped_ack),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  // Observation word: {main[1:0], side[1:0], walk, ped_ack, phase[2:0]}
  function automatic logic [8:0] obs();
    return {main_light, side_light, walk, ped_ack, phase};
  endfunction

  function automatic logic [8:0] e(input logic [1:0] m, input logic [1:0] s,
                                   input logic w, input logic a, input logic [2:0] p);
    return {m, s, w, a, p};
  endfunction

  task automatic check(input string name, input logic [8:0] actual, input logic [8:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got main/side/walk/ack/phase=%b_%b_%b_%b_%b expected %b_%b_%b_%b_%b",
               name, actual[8:7], actual[6:5], actual[4], actual[3], actual[2:0],
               expected[8:7], expected[6:5], expected[4], expected[3], expected[2:0]);
    end
  endtask

  // The two roads never both leave red, 11 is never driven, and walk only shows with both red.
  always @(negedge clk) begin
    if (inv_on && reset) begin
      n_tests++;
      if ((main_light != 2'b00 && side_light != 2'b00) || main_light == 2'b11 ||
          side_light == 2'b11 || (walk && (main_light != 2'b00 || side_light != 2'b00))) begin
        n_fail++;
        $display("FAIL invariant: main=%b side=%b walk=%b", main_light, side_light, walk);
      end
    end
  end

  typedef struct {
    logic       side;
    logic       ped;
    int         reps;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic p, input int n, input logic [8:0] x);
    vec_t v;
    v.side = s; v.ped = p; v.reps = n; v.exp = x;
    vecs.push_back(v);
  endtask

  // Each cycle: check outputs at negedge, then drive the inputs for the coming edge.
  // ped is pulsed only on the first cycle of a row.
  task automatic run_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        @(negedge clk);
        check($sformatf("%s row%0d cyc%0d", tag, i, r), obs(), vecs[i].exp);
        side_req = vecs[i].side;
        ped_req  = (r == 0) ? vecs[i].ped : 1'b0;
        tick     = 1'b1;
      end
    end
    vecs.delete();
  endtask

  // Reset is released just after a rising edge, so the next negedge still shows RED_M.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; side_req = 1'b0; ped_req = 1'b0; tick = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  // Reference model: phase index (the spec's phase code), ticks spent in the phase, requests.
  int dur [7] = '{1, 8, 3, 1, 6, 3, 5};
  logic [1:0] main_tab [7] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
  logic [1:0] side_tab [7] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00};
  int m_ph, m_ticks;
  bit m_pend, m_for_walk, m_ack;

  task automatic model_reset();
    m_ph = 0; m_ticks = 0; m_pend = 0; m_for_walk = 0; m_ack = 0;
  endtask

  function automatic logic [8:0] model_obs();
    return {main_tab[m_ph], side_tab[m_ph], logic'(m_ph == 6), logic'(m_ack), 3'(m_ph)};
  endfunction

  task automatic model_edge(input bit s, input bit p, input bit t);
    int nxt = m_ph;
    bit done = t && (m_ticks + 1 >= dur[m_ph]);
    bit entering;
    if (m_ph == 1) begin
      if (done && m_pend) begin nxt = 2; m_for_walk = 1; end
      else if (done && s) begin nxt = 2; m_for_walk = 0; end
    end else if (m_ph == 4) begin
      if (t && (!s || m_ticks + 1 >= dur[4])) nxt = 5;
    end else if (done) begin
      case (m_ph)
        0: nxt = 1;
        2: nxt = 3;
        3: nxt = m_for_walk ? 6 : 4;
        default: nxt = 0;
      endcase
    end
    entering = (nxt == 6) && (m_ph != 6);
    m_pend = p || (m_pend && !entering);
    m_ack  = entering;
    if (nxt != m_ph) m_ticks = 0;
    else if (t) m_ticks++;
    m_ph = nxt;
  endtask

  // mode 0: random tick; mode 1: tick every 4th cycle with side_req held high
  task automatic run_model(input string tag, input int cycles, input int mode);
    bit s = 0;
    bit p, t;
    do_reset();
    model_reset();
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      check($sformatf("%s cyc%0d", tag, c), obs(), model_obs());
      if (mode == 1) begin
        s = 1; p = 0; t = (c % 4 == 0);
      end else begin
        if ($urandom_range(0, 7) == 0) s = ~s;
        p = ($urandom_range(0, 29) == 0);
        t = ($urandom_range(0, 3) != 0);
      end
      side_req = s; ped_req = p; tick = t;
      model_edge(s, p, t);
    end
  endtask

  initial begin
    reset = 1'b0;
    #1;
    check("reset outputs", obs(), 9'b0);
    inv_on = 1'b1;

    // Side max-out cycle, then a pedestrian press served ahead of the side request.
    do_reset();
    add(1, 0, 1, e(2'b00, 2'b00, 0, 0, 3'd0));
    add(1, 0, 8, e(2'b01, 2'b00, 0, 0, 3'd1));
    add(1, 0, 3, e(2'b10, 2'b00, 0, 0, 3'd2));
    add(1, 0, 1, e(2'b00, 2'b00, 0, 0, 3'd3));
    add(1, 0, 6, e(2'b00, 2'b01, 0, 0, 3'd4));
    add(1, 0, 3, e(2'b00, 2'b10, 0, 0, 3'd5));
    add(1, 0, 1, e(2'b00, 2'b00, 0, 0, 3'd0));
    add(1, 1, 1, e(2'b01, 2'b00, 0, 0, 3'd1));
    add(1, 0, 7, e(2'b01, 2'b00, 0, 0, 3'd1));
    add(1, 0, 3, e(2'b10, 2'b00, 0, 0, 3'd2));
    add(1, 0, 1, e(2'b00, 2'b00, 0, 0, 3'd3));
    add(1, 0, 1, e(2'b00, 2'b00, 1, 1, 3'd6));
    add(1, 0, 4, e(2'b00, 2'b00, 1, 0, 3'd6));
    add(1, 0, 1, e(2'b00, 2'b00, 0, 0, 3'd0));
    add(1, 0, 8, e(2'b01, 2'b00, 0, 0, 3'd1));
    add(1, 0, 3, e(2'b10, 2'b00, 0, 0, 3'd2));
    add(1, 0, 1, e(2'b00, 2'b00, 0, 0, 3'd3));
    add(1, 0, 1, e(2'b00, 2'b01, 0, 0, 3'd4));
    run_vecs("maxout_ped");

    // Gap-out after two side-green cycles, then main green rests with no requests.
    do_reset();
    add(1, 0, 1,   e(2'b00, 2'b00, 0, 0, 3'd0));
    add(1, 0, 8,   e(2'b01, 2'b00, 0, 0, 3'd1));
    add(1, 0, 3,   e(2'b10, 2'b00, 0, 0, 3'd2));
    add(1, 0, 1,   e(2'b00, 2'b00, 0, 0, 3'd3));
    add(1, 0, 2,   e(2'b00, 2'b01, 0, 0, 3'd4));
    add(0, 0, 1,   e(2'b00, 2'b01, 0, 0, 3'd4));
    add(0, 0, 3,   e(2'b00, 2'b10, 0, 0, 3'd5));
    add(0, 0, 1,   e(2'b00, 2'b00, 0, 0, 3'd0));
    add(0, 0, 200, e(2'b01, 2'b00, 0, 0, 3'd1));
    run_vecs("gapout_idle");

    // A press during the walk-entry cycle and during WALK earns a second walk phase.
    do_reset();
    add(0, 1, 1, e(2'b00, 2'b00, 0, 0, 3'd0));
    add(0, 0, 8, e(2'b01, 2'b00, 0, 0, 3'd1));
    add(0, 0, 3, e(2'b10, 2'b00, 0, 0, 3'd2));
    add(0, 1, 1, e(2'b00, 2'b00, 0, 0, 3'd3));
    add(0, 1, 1, e(2'b00, 2'b00, 1, 1, 3'd6));
    add(0, 0, 4, e(2'b00, 2'b00, 1, 0, 3'd6));
    add(0, 0, 1, e(2'b00, 2'b00, 0, 0, 3'd0));
    add(0, 0, 8, e(2'b01, 2'b00, 0, 0, 3'd1));
    add(0, 0, 3, e(2'b10, 2'b00, 0, 0, 3'd2));
    add(0, 0, 1, e(2'b00, 2'b00, 0, 0, 3'd3));
    add(0, 0, 1, e(2'b00, 2'b00, 1, 1, 3'd6));
    add(0, 0, 4, e(2'b00, 2'b00, 1, 0, 3'd6));
    add(0, 0, 1, e(2'b00, 2'b00, 0, 0, 3'd0));
    add(0, 0, 3, e(2'b01, 2'b00, 0, 0, 3'd1));
    run_vecs("ped_repress");

    // Asynchronous reset in the middle of SIDE_G takes effect before the next edge.
    do_reset();
    add(1, 0, 1, e(2'b00, 2'b00, 0, 0, 3'd0));
    add(1, 0, 8, e(2'b01, 2'b00, 0, 0, 3'd1));
    add(1, 0, 3, e(2'b10, 2'b00, 0, 0, 3'd2));
    add(1, 0, 1, e(2'b00, 2'b00, 0, 0, 3'd3));
    add(1, 0, 2, e(2'b00, 2'b01, 0, 0, 3'd4));
    run_vecs("pre_async");
    #1 reset = 1'b0;
    #1 check("async reset mid SIDE_G", obs(), 9'b0);

    run_model("tick_div4", 300, 1);
    run_model("random", 3000, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
